// File: rtl/periph_bus.sv
`default_nettype none
// ============================================================================
//  Module      : periph_bus
//  Description : Single-outstanding request/response bridge to four simple
//                peripheral slots. Writes and reads are issued as one-cycle
//                one-hot strobes; read data is captured RD_LATENCY cycles
//                after the strobe. Slots 4..15 are unmapped and complete
//                immediately without any strobe.
//                Optional feature macro: PERIPH_BUS_ERR_EN
//                  defined   -> rsp_err flags accesses to unmapped slots
//                  undefined -> rsp_err is tied low
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_bus #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    // initiator request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    // initiator response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    // peripheral side
    output logic [3:0]  p_ren,
    output logic [3:0]  p_wen,
    output logic [3:0]  p_addr,
    output logic [7:0]  p_wdata,
    input  logic [31:0] p_rdata
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // Counter value reached in the final WAIT cycle
    localparam logic [2:0] c_WAIT_LAST = 3'(RD_LATENCY - 1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic [1:0] r_slot;      // slot index, only meaningful when r_mapped
    logic       r_mapped;    // accepted address targets slot 0..3
    logic       r_we;
    logic [2:0] r_cnt;       // WAIT cycle counter
    logic [7:0] r_rdata;
    logic       r_err;
    logic [3:0] r_paddr;
    logic [7:0] r_pwdata;

    logic       w_accept;
    logic       w_req_mapped;
    logic       w_err_nxt;
    logic       w_wait_done;
    logic       w_rsp_hs;
    logic [3:0] w_slot_oh;
    logic [7:0] w_slot_byte;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign w_accept     = req_valid && (r_state == c_IDLE);
    assign w_req_mapped = (req_addr[7:6] == 2'b00);
    assign w_wait_done  = (r_state == c_WAIT) && (r_cnt == c_WAIT_LAST);
    assign w_rsp_hs     = (r_state == c_RESP) && rsp_ready;
    assign w_slot_oh    = 4'b0001 << r_slot;
    assign w_slot_byte  = p_rdata[{r_slot, 3'b000} +: 8];

`ifdef PERIPH_BUS_ERR_EN
    assign w_err_nxt = ~w_req_mapped;
`else
    assign w_err_nxt = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_req_mapped ? c_ISSUE : c_RESP;
                end
            end
            c_ISSUE: begin
                w_state_nxt = r_we ? c_RESP : c_WAIT;
            end
            c_WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs: handshakes and one-cycle strobes derived from state
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        p_ren     = 4'b0000;
        p_wen     = 4'b0000;
        case (r_state)
            c_IDLE: begin
                req_ready = 1'b1;
            end
            c_ISSUE: begin
                // ISSUE is only ever entered for mapped slots
                if (r_mapped) begin
                    if (r_we) begin
                        p_wen = w_slot_oh;
                    end else begin
                        p_ren = w_slot_oh;
                    end
                end
            end
            c_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture: peripheral address/data hold their last accepted value
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_paddr  <= 4'h0;
            r_pwdata <= 8'h00;
            r_slot   <= 2'd0;
            r_mapped <= 1'b0;
            r_we     <= 1'b0;
        end else if (w_accept) begin
            r_paddr  <= req_addr[3:0];
            r_pwdata <= req_wdata;
            r_slot   <= req_addr[5:4];
            r_mapped <= w_req_mapped;
            r_we     <= req_we;
        end
    end

    // ------------------------------------------------------------------------
    // WAIT counter: runs only while waiting, cleared otherwise
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if ((r_state == c_WAIT) && !w_wait_done) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= 3'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Response data/error: zeroed on accept, read byte captured at WAIT end,
    // otherwise held so the response stays stable under backpressure
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= 8'h00;
            r_err   <= w_err_nxt;
        end else if (w_wait_done) begin
            r_rdata <= w_slot_byte;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign p_addr    = r_paddr;
    assign p_wdata   = r_pwdata;

endmodule
`default_nettype wire

// File: doc/periph_bus.md
PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1: cycles from a p_ren strobe to valid p_rdata, legal range 1..7.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: initiator request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted when high together with req_valid.
REQ-006 SHALL have port req_addr, input, 8: [7:4] peripheral slot, [3:0] register index.
REQ-007 SHALL have port req_we, input, 1: 1 write, 0 read.
REQ-008 SHALL have port req_wdata, input, 8: write data.
REQ-009 SHALL have port rsp_valid, output, 1: response present.
REQ-010 SHALL have port rsp_ready, input, 1: response consumed when high together with rsp_valid.
REQ-011 SHALL have port rsp_rdata, output, 8: read data.
REQ-012 SHALL have port rsp_err, output, 1: unmapped-slot error flag.
REQ-013 SHALL have port p_ren, output, 4: per-slot one-hot read strobe.
REQ-014 SHALL have port p_wen, output, 4: per-slot one-hot write strobe.
REQ-015 SHALL have port p_addr, output, 4: register index to peripherals.
REQ-016 SHALL have port p_wdata, output, 8: write data to peripherals.
REQ-017 SHALL have port p_rdata, input, 32: slot n read data on bits [8n+7:8n].

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready high only in IDLE.
REQ-019 SHALL, on acceptance, register req_addr[3:0] to p_addr, req_wdata to p_wdata, and latch slot, we; go to ISSUE if slot < 4, else RESP.
REQ-020 SHALL, in ISSUE, assert exactly one bit of p_wen (write) or p_ren (read) for exactly one cycle, slot index = bit index.
REQ-021 SHALL go ISSUE -> RESP for writes; ISSUE -> WAIT for reads.
REQ-022 SHALL stay in WAIT for RD_LATENCY cycles (3-bit counter), sample the slot's p_rdata byte at the edge ending the last WAIT cycle, then enter RESP.
REQ-023 SHALL, in RESP, hold rsp_valid, rsp_rdata, rsp_err stable until rsp_valid and rsp_ready are both high, then return to IDLE.
REQ-024 SHALL give latency accept->rsp_valid: write 2 cycles, read 2+RD_LATENCY cycles, unmapped 1 cycle.
REQ-025 SHALL drive rsp_rdata = 0x00 for writes and unmapped accesses.
REQ-026 SHALL never assert p_ren or p_wen outside ISSUE, nor for unmapped slots.
REQ-027 SHALL hold p_addr and p_wdata at last accepted values between transactions.
REQ-028 SHALL allow a new request to be accepted the cycle after the RESP handshake (IDLE), giving no back-to-back overlap.

Reset
REQ-029 SHALL, when rst is high at a clock edge, enter IDLE and clear rsp_valid, rsp_err, rsp_rdata, p_ren, p_wen, p_addr, p_wdata, and the WAIT counter to 0.
REQ-030 SHALL discard any in-flight transaction on rst (mid-ISSUE/WAIT/RESP), with no further strobes and no response issued.
REQ-031 SHALL drive req_ready high from the first cycle after rst deasserts.

Configuration
REQ-032 SHALL, with PERIPH_BUS_ERR_EN defined, set rsp_err = 1 for accesses with req_addr[7:4] >= 4.
REQ-033 SHALL, without PERIPH_BUS_ERR_EN, tie rsp_err to 0; unmapped accesses still complete in 1 cycle, with reads returning 0x00 and writes silently dropped.

Verification
REQ-034 SHALL verify write: write addr 0x12, data 0xA5 -> p_wen = 0b0010 for one cycle with p_addr = 0x2, p_wdata = 0xA5; rsp_valid 2 cycles after accept, rsp_err = 0.
REQ-035 SHALL verify read: p_rdata[23:16] = 0x3C, read addr 0x20, RD_LATENCY = 1 -> p_ren = 0b0100 for one cycle; rsp_rdata = 0x3C at 3 cycles after accept.
REQ-036 SHALL verify backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout, no extra strobes.
REQ-037 SHALL verify unmapped access: read 0x50 with ERR_EN -> rsp_err = 1, rsp_rdata = 0x00, no strobes; without ERR_EN -> rsp_err = 0.
REQ-038 SHALL verify reset in WAIT: RD_LATENCY = 4, rst pulsed in the 2nd WAIT cycle -> IDLE next cycle, rsp_valid never rises, req_ready = 1.
REQ-039 SHALL verify back-to-back: write 0x01 then read 0x01 with rsp_ready tied high -> second accept one cycle after first handshake, strobes never overlap.
